sample_fetch_responder: RTL

//  Responder end of the toggle read handshake used by the wave sample player:

---
 rtl/sample_fetch_if.sv | 27 ++
 rtl/sample_fetch_responder.sv | 102 ++++++++++
 2 files changed

// File: rtl/sample_fetch_if.sv
// Requester-side toggle handshake plus the SDRAM 16-bit word-read port, bundled for the
// sample fetch responder. The slave modport is the responder's view.
interface sample_fetch_if #(
  parameter int unsigned ADDR_W = 25
);
  logic [ADDR_W-1:0] s_addr;
  logic              s_rd;
  logic              s_ack;
  logic [63:0]       s_dout;
  logic              inv;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W+1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_valid;
  logic [15:0]       mem_q;

  modport slave (
    input  s_addr, s_rd, inv, mem_gnt, mem_valid, mem_q,
    output s_ack, s_dout, busy, mem_req, mem_addr
  );

  modport master (
    output s_addr, s_rd, inv, mem_gnt, mem_valid, mem_q,
    input  s_ack, s_dout, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/sample_fetch_responder.sv
// Serves toggle read requests with one 64-bit word fetched as four 16-bit SDRAM reads,
// backed by a single-line cache of the last fetched word.
module sample_fetch_responder #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic           clk_sys,
  input logic           reset,
  sample_fetch_if.slave bus
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] a_lat_q;
  logic [ADDR_W-1:0] tag_q;
  logic [1:0]        k_q;
  logic [CntW-1:0]   cnt_q;
  logic [3:0][15:0]  line_q;
  logic              valid_q;
  logic              inv_seen_q;
  logic              pending;

  assign pending = bus.s_rd ^ bus.s_ack;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      a_lat_q      <= '0;
      tag_q        <= '0;
      k_q          <= 2'd0;
      cnt_q        <= '0;
      line_q       <= '0;
      valid_q      <= 1'b0;
      inv_seen_q   <= 1'b0;
      bus.s_ack    <= 1'b0;
      bus.s_dout   <= '0;
      bus.busy     <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      if (bus.inv) valid_q <= 1'b0;
      // A fetch that overlaps an invalidate must not install its tag.
      if (bus.inv && state_q != StIdle) inv_seen_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (pending && !bus.inv) begin
            a_lat_q <= bus.s_addr;
            if (valid_q && tag_q == bus.s_addr) begin
              bus.s_dout <= line_q;
              bus.s_ack  <= ~bus.s_ack;
            end else begin
              k_q          <= 2'd0;
              inv_seen_q   <= 1'b0;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {bus.s_addr, 2'd0};
              bus.busy     <= 1'b1;
              state_q      <= StIssue;
            end
          end
        end
        StIssue: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.mem_valid) begin
            line_q[k_q] <= bus.mem_q;
            if (k_q == 2'd3) begin
              state_q <= StDone;
            end else begin
              k_q          <= k_q + 2'd1;
              bus.mem_req  <= 1'b1;
              bus.mem_addr <= {a_lat_q, k_q + 2'd1};
              state_q      <= StIssue;
            end
          end else if (cnt_q == CntW'(TIMEOUT)) begin
            // Lost read: reissue the same 16-bit word, mem_addr is still held.
            bus.mem_req <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StDone: begin
          bus.s_dout <= line_q;
          bus.s_ack  <= ~bus.s_ack;
          tag_q      <= a_lat_q;
          valid_q    <= !(inv_seen_q || bus.inv);
          bus.busy   <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

endmodule
